// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared types and constants for the PS/2 keyboard decoder:
//                frame-receiver state encoding, prefix bytes and the
//                controller/status bytes that never produce a key event.
//  Optional    : none (PS2_PARITY_CHECK_EN is consumed by ps2_frame_rx)
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Device-to-host frame position
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    // Prefix bytes
    localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;

    // Controller / status bytes
    localparam logic [7:0] PS2_STAT_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_STAT_ACK    = 8'hFA;
    localparam logic [7:0] PS2_STAT_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_STAT_RESEND = 8'hFE;
    localparam logic [7:0] PS2_STAT_ERR0   = 8'h00;
    localparam logic [7:0] PS2_STAT_ERRF   = 8'hFF;

    function automatic logic is_status_byte(input logic [7:0] b);
        return (b == PS2_STAT_BAT_OK) || (b == PS2_STAT_ACK)    ||
               (b == PS2_STAT_ECHO)   || (b == PS2_STAT_RESEND) ||
               (b == PS2_STAT_ERR0)   || (b == PS2_STAT_ERRF);
    endfunction

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_frame_rx
//  Description : Synchronises raw PS/2 clock/data, detects ps2_clk falling
//                edges and de-frames 11-bit device-to-host frames
//                (start, 8 data LSB first, parity, stop). A partial frame
//                idle for TIMEOUT_CYC cycles is discarded.
//  Optional    : PS2_PARITY_CHECK_EN - when defined, odd parity is enforced
//                in the STOP state; otherwise the parity bit is ignored.
//  Ports       : clk_sys, reset_n (sync, active-low), ps2_clk, ps2_data (raw,
//                async) -> byte_rdy (1-cycle), rx_byte[7:0], frame_err
//                (1-cycle pulse).
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 24000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_rdy,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT_CYC - 1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;
    logic                   w_clk;
    logic                   w_data;
    logic                   w_fall;

    frame_state_t    r_state, w_state_d;
    logic [2:0]      r_bit_cnt, w_bit_cnt_d;
    logic [7:0]      r_shift, w_shift_d;
    logic [TO_W-1:0] r_to_cnt, w_to_cnt_d;
    logic            r_byte_rdy, w_byte_rdy_d;
    logic            r_frame_err, w_frame_err_d;
    logic            w_stop_ok;

    // Synchronisers reset to the idle-bus level (both lines high) so that
    // reset release does not fabricate a falling edge on an idle bus.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
            r_clk_prev  <= w_clk;
        end
    end

    assign w_clk  = r_clk_sync[SYNC_STAGES-1];
    assign w_data = r_data_sync[SYNC_STAGES-1];
    assign w_fall = r_clk_prev & ~w_clk;

`ifdef PS2_PARITY_CHECK_EN
    logic r_parity, w_parity_d;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) r_parity <= 1'b0;
        else          r_parity <= w_parity_d;
    end

    // Odd parity over the data byte plus the parity bit
    assign w_stop_ok = w_data & (^{r_shift, r_parity});
`else
    assign w_stop_ok = w_data;
`endif

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_to_cnt    <= '0;
            r_byte_rdy  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_bit_cnt   <= w_bit_cnt_d;
            r_shift     <= w_shift_d;
            r_to_cnt    <= w_to_cnt_d;
            r_byte_rdy  <= w_byte_rdy_d;
            r_frame_err <= w_frame_err_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_bit_cnt_d   = r_bit_cnt;
        w_shift_d     = r_shift;
        w_byte_rdy_d  = 1'b0;
        w_frame_err_d = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        w_parity_d    = r_parity;
`endif
        w_to_cnt_d    = (w_fall || r_state == IDLE) ? '0 : r_to_cnt + TO_W'(1);

        if (w_fall) begin
            case (r_state)
                IDLE: begin
                    // A high start bit is silently ignored
                    if (!w_data) begin
                        w_state_d   = SHIFT;
                        w_bit_cnt_d = '0;
                    end
                end
                SHIFT: begin
                    w_shift_d   = {w_data, r_shift[7:1]};
                    w_bit_cnt_d = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) w_state_d = PARITY;
                end
                PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    w_parity_d = w_data;
`endif
                    w_state_d  = STOP;
                end
                STOP: begin
                    w_state_d = IDLE;
                    if (w_stop_ok) w_byte_rdy_d  = 1'b1;
                    else           w_frame_err_d = 1'b1;
                end
                default: w_state_d = IDLE;
            endcase
        end else if (r_state != IDLE && r_to_cnt == c_to_last) begin
            // Timeout only fires on a cycle without an edge
            w_state_d     = IDLE;
            w_bit_cnt_d   = '0;
            w_to_cnt_d    = '0;
            w_frame_err_d = 1'b1;
        end
    end

    assign byte_rdy  = r_byte_rdy;
    assign rx_byte   = r_shift;
    assign frame_err = r_frame_err;

endmodule : ps2_frame_rx
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_decoder
//  Description : PS/2 keyboard receiver. Folds E0 (extended), F0 (break) and
//                E1 (Pause, skipped) prefixes into one key event per key and
//                presents it as a single-cycle strobe. Receive-only.
//  Optional    : PS2_PARITY_CHECK_EN - enforce odd parity on received frames.
//  Ports       : clk_sys, reset_n (sync, active-low), ps2_clk, ps2_data (raw)
//                -> key_strobe, key_pressed, key_extended, key_code[7:0],
//                frame_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 24000,
    parameter int E1_SKIP     = 7
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_strobe,
    output logic       key_pressed,
    output logic       key_extended,
    output logic [7:0] key_code,
    output logic       frame_err
);

    // +2 keeps the width at least 1 bit even when E1_SKIP is 0
    localparam int SKIP_W = $clog2(E1_SKIP + 2);

    logic              w_byte_rdy;
    logic [7:0]        w_byte;
    logic              w_frame_err;
    logic              r_ext;
    logic              r_brk;
    logic [SKIP_W-1:0] r_skip;

    ps2_frame_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame_rx (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_rdy  (w_byte_rdy),
        .rx_byte   (w_byte),
        .frame_err (w_frame_err)
    );

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            key_strobe   <= 1'b0;
            key_pressed  <= 1'b0;
            key_extended <= 1'b0;
            key_code     <= '0;
            r_ext        <= 1'b0;
            r_brk        <= 1'b0;
            r_skip       <= '0;
        end else begin
            key_strobe <= 1'b0;
            if (w_frame_err) begin
                // A corrupted frame may have been a prefix; forget the
                // pending prefixes but keep any Pause skip in progress.
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (w_byte_rdy) begin
                if (r_skip != '0) begin
                    r_skip <= r_skip - SKIP_W'(1);
                end else if (w_byte == PS2_PFX_PAUSE) begin
                    r_skip <= SKIP_W'(E1_SKIP);
                end else if (w_byte == PS2_PFX_EXT) begin
                    r_ext <= 1'b1;
                end else if (w_byte == PS2_PFX_BRK) begin
                    r_brk <= 1'b1;
                end else if (is_status_byte(w_byte)) begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end else begin
                    key_strobe   <= 1'b1;
                    key_code     <= w_byte;
                    key_pressed  <= ~r_brk;
                    key_extended <= r_ext;
                    r_ext        <= 1'b0;
                    r_brk        <= 1'b0;
                end
            end
        end
    end

    assign frame_err = w_frame_err;

endmodule : ps2_key_decoder
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_key_decoder
//  Description : Directed self-checking bench for ps2_key_decoder. Drives
//                PS/2 frames bit by bit and checks strobes, key fields,
//                frame_err pulses and strobe latency with immediate asserts.
//  Optional    : PS2_PARITY_CHECK_EN changes the expected bad-parity result.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;

    localparam int TO_CYC = 200;
    localparam int HALF   = 8;     // clk_sys cycles per PS/2 clock half-period

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_strobe;
    logic       key_pressed;
    logic       key_extended;
    logic [7:0] key_code;
    logic       frame_err;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_strobe = 0;
    int n_ferr = 0;
    int strobe_cyc = 0;
    int fall_cyc = 0;
    int base_s;
    int base_e;

    ps2_key_decoder #(
        .SYNC_STAGES (2),
        .TIMEOUT_CYC (TO_CYC),
        .E1_SKIP     (7)
    ) dut (
        .clk_sys      (clk),
        .reset_n      (reset_n),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .key_strobe   (key_strobe),
        .key_pressed  (key_pressed),
        .key_extended (key_extended),
        .key_code     (key_code),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (key_strobe) begin
            n_strobe   = n_strobe + 1;
            strobe_cyc = cyc;
        end
        if (frame_err) n_ferr = n_ferr + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sends bits[0..n-1] of an LSB-first bit vector on the PS/2 lines
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk  = 1'b0;
            fall_cyc = cyc;
            repeat (HALF) @(negedge clk);
            ps2_clk  = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        send_bits({stp, par, d, 1'b0}, 11);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_frame(d, ~^d, 1'b1);
    endtask

    task automatic settle();
        repeat (20) @(negedge clk);
    endtask

    task automatic mark();
        base_s = n_strobe;
        base_e = n_ferr;
    endtask

    initial begin
        // ---------------- reset ----------------
        repeat (4) @(negedge clk);
        chk("rst_strobe",   {31'd0, key_strobe},   32'd0);
        chk("rst_pressed",  {31'd0, key_pressed},  32'd0);
        chk("rst_extended", {31'd0, key_extended}, 32'd0);
        chk("rst_code",     {24'd0, key_code},     32'd0);
        chk("rst_ferr",     {31'd0, frame_err},    32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // ---------------- make 'A' (0x1C, parity 0) ----------------
        mark();
        send_frame(8'h1C, 1'b0, 1'b1);
        settle();
        chk("make_count",   n_strobe - base_s, 32'd1);
        chk("make_code",    {24'd0, key_code}, 32'h1C);
        chk("make_pressed", {31'd0, key_pressed},  32'd1);
        chk("make_ext",     {31'd0, key_extended}, 32'd0);
        // 2 synchroniser stages + 2 cycles of decode
        chk("make_latency", strobe_cyc - fall_cyc, 32'd4);
        repeat (50) @(negedge clk);
        chk("make_hold_code",    {24'd0, key_code},    32'h1C);
        chk("make_hold_pressed", {31'd0, key_pressed}, 32'd1);
        chk("make_hold_strobe",  {31'd0, key_strobe},  32'd0);

        // ---------------- break Up: E0 F0 75 ----------------
        mark();
        send_byte(8'hE0);
        send_byte(8'hF0);
        settle();
        chk("brk_prefix_nostrobe", n_strobe - base_s, 32'd0);
        send_byte(8'h75);
        settle();
        chk("brk_count",   n_strobe - base_s, 32'd1);
        chk("brk_code",    {24'd0, key_code},     32'h75);
        chk("brk_pressed", {31'd0, key_pressed},  32'd0);
        chk("brk_ext",     {31'd0, key_extended}, 32'd1);

        // ---------------- timeout then 0x29 ----------------
        mark();
        send_bits({3'b110, 8'h29, 1'b0}, 5);
        repeat (TO_CYC + 20) @(negedge clk);
        chk("to_ferr",     n_ferr - base_e,   32'd1);
        chk("to_nostrobe", n_strobe - base_s, 32'd0);
        send_byte(8'h29);
        settle();
        chk("to_count",   n_strobe - base_s, 32'd1);
        chk("to_code",    {24'd0, key_code},     32'h29);
        chk("to_pressed", {31'd0, key_pressed},  32'd1);
        chk("to_ext",     {31'd0, key_extended}, 32'd0);

        // ---------------- Pause sequence then 0x16 ----------------
        mark();
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        settle();
        chk("pause_nostrobe", n_strobe - base_s, 32'd0);
        send_byte(8'h16);
        settle();
        chk("pause_count",   n_strobe - base_s, 32'd1);
        chk("pause_code",    {24'd0, key_code},    32'h16);
        chk("pause_pressed", {31'd0, key_pressed}, 32'd1);

        // ---------------- status byte clears flags ----------------
        mark();
        send_byte(8'hE0);
        send_byte(8'hFA);
        send_byte(8'h1D);
        settle();
        chk("stat_count", n_strobe - base_s, 32'd1);
        chk("stat_code",  {24'd0, key_code},     32'h1D);
        chk("stat_ext",   {31'd0, key_extended}, 32'd0);

        // ---------------- bad stop bit on 0x45 ----------------
        mark();
        send_frame(8'h45, ~^8'h45, 1'b0);
        settle();
        chk("stop_ferr",     n_ferr - base_e,   32'd1);
        chk("stop_nostrobe", n_strobe - base_s, 32'd0);
        chk("stop_code",     {24'd0, key_code}, 32'h1D);

        // ---------------- bad parity on 0x45 ----------------
        mark();
        send_frame(8'h45, ^8'h45, 1'b1);
        settle();
`ifdef PS2_PARITY_CHECK_EN
        chk("par_ferr",     n_ferr - base_e,   32'd1);
        chk("par_nostrobe", n_strobe - base_s, 32'd0);
`else
        chk("par_ferr",  n_ferr - base_e,   32'd0);
        chk("par_count", n_strobe - base_s, 32'd1);
        chk("par_code",  {24'd0, key_code}, 32'h45);
`endif

        // ---------------- frame_err clears a pending E0 ----------------
        mark();
        send_byte(8'hE0);
        send_frame(8'h33, ~^8'h33, 1'b0);
        send_byte(8'h6B);
        settle();
        chk("errclr_count", n_strobe - base_s, 32'd1);
        chk("errclr_code",  {24'd0, key_code},     32'h6B);
        chk("errclr_ext",   {31'd0, key_extended}, 32'd0);

        // ---------------- reset mid-frame then 0x5A ----------------
        send_bits({3'b110, 8'h5A, 1'b0}, 5);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mrst_strobe",  {31'd0, key_strobe},   32'd0);
        chk("mrst_pressed", {31'd0, key_pressed},  32'd0);
        chk("mrst_ext",     {31'd0, key_extended}, 32'd0);
        chk("mrst_code",    {24'd0, key_code},     32'd0);
        chk("mrst_ferr",    {31'd0, frame_err},    32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        mark();
        send_byte(8'h5A);
        settle();
        chk("mrst_count",   n_strobe - base_s, 32'd1);
        chk("mrst_code2",   {24'd0, key_code},    32'h5A);
        chk("mrst_pressed2", {31'd0, key_pressed}, 32'd1);
        chk("mrst_noferr",  n_ferr - base_e, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ps2_key_decoder
`default_nettype wire
